// File: rtl/hack_pkg.sv
// ============================================================================
// hack_pkg : shared states, instruction field positions and data width
// Rev 1.0
// ============================================================================
`default_nettype none

package hack_pkg;

  localparam int unsigned DW = 16;

  localparam int unsigned CI      = 15;
  localparam int unsigned ABIT    = 12;
  localparam int unsigned COMP_HI = 11;
  localparam int unsigned COMP_LO = 6;
  localparam int unsigned DEST_HI = 5;
  localparam int unsigned DEST_LO = 3;
  localparam int unsigned JMP_HI  = 2;
  localparam int unsigned JMP_LO  = 0;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC   = 3'd1,
    MEM_RD = 3'd2,
    WB     = 3'd3,
    MEM_WR = 3'd4,
    HALT   = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hack_jump_eval.sv
// ============================================================================
// hack_jump_eval : Hack jump condition from j-bits and ALU flags
// Rev 1.0
// ============================================================================
`default_nettype none

module hack_jump_eval (
  input  logic [2:0] j_i,
  input  logic       zr_i,
  input  logic       ng_i,
  output logic       take_o
);

  assign take_o = (j_i[2] & ng_i) | (j_i[1] & zr_i) | (j_i[0] & ~ng_i & ~zr_i);

endmodule

`default_nettype wire

// File: rtl/hack_cpu_ctrl.sv
// ============================================================================
// hack_cpu_ctrl : multi-cycle Hack CPU control/datapath around an external ALU
// Optional halt detection: define HACK_CPU_HALT_DET_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int unsigned     AW       = 15,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [15:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [15:0]   dmem_wdata,
  input  logic          dmem_ack,
  input  logic [15:0]   dmem_rdata,
  output logic [15:0]   alu_x,
  output logic [15:0]   alu_y,
  output logic [5:0]    alu_ctl,
  input  logic [15:0]   alu_out,
  input  logic          alu_zr,
  input  logic          alu_ng,
  output logic [AW-1:0] pc_o,
  output logic [15:0]   a_o,
  output logic [15:0]   d_o,
  output logic          retire,
  output logic          halted
);

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d, pcpend_q, pcpend_d, aold_q, aold_d;
  logic [DW-1:0]   a_q, a_d, d_q, d_d, ir_q, ir_d, m_q, m_d, wdata_q, wdata_d;
  logic            retire_q, retire_d;
  logic [1:0]      rst_sync_q;
  logic [AW-1:0]   pc_inc, pc_wb;
  logic            take;

  hack_jump_eval u_jump (
    .j_i    (ir_q[JMP_HI:JMP_LO]),
    .zr_i   (alu_zr),
    .ng_i   (alu_ng),
    .take_o (take)
  );

  assign pc_inc = pc_q + AW'(1);
  assign pc_wb  = take ? a_q[AW-1:0] : pc_inc;

  // Release is synchronised so the first fetch request never races rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

`ifdef HACK_CPU_HALT_DET_EN
  logic halted_q, halted_d, hpend_q, hpend_d, halt_hit;
  assign halt_hit = (ir_q[JMP_HI:JMP_LO] == 3'b111) && (a_q[AW-1:0] == pc_q);
  assign halted   = halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
      hpend_q  <= 1'b0;
    end else begin
      halted_q <= halted_d;
      hpend_q  <= hpend_d;
    end
  end
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      pcpend_q <= '0;
      aold_q   <= '0;
      a_q      <= '0;
      d_q      <= '0;
      ir_q     <= '0;
      m_q      <= '0;
      wdata_q  <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pcpend_q <= pcpend_d;
      aold_q   <= aold_d;
      a_q      <= a_d;
      d_q      <= d_d;
      ir_q     <= ir_d;
      m_q      <= m_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pcpend_d = pcpend_q;
    aold_d   = aold_q;
    a_d      = a_q;
    d_d      = d_q;
    ir_d     = ir_q;
    m_d      = m_q;
    wdata_d  = wdata_q;
    retire_d = 1'b0;
`ifdef HACK_CPU_HALT_DET_EN
    halted_d = halted_q;
    hpend_d  = hpend_q;
`endif
    case (state_q)
      FETCH: begin
        if (imem_req && imem_valid) begin
          ir_d    = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!ir_q[CI]) begin
          a_d      = {1'b0, ir_q[CI-1:0]};
          pc_d     = pc_inc;
          retire_d = 1'b1;
          state_d  = FETCH;
        end else if (ir_q[ABIT]) begin
          state_d = MEM_RD;
        end else begin
          state_d = WB;
        end
      end
      MEM_RD: begin
        if (dmem_ack) begin
          m_d     = dmem_rdata;
          state_d = WB;
        end
      end
      WB: begin
        // Store address and jump target come from A before this write-back.
        aold_d   = a_q[AW-1:0];
        wdata_d  = alu_out;
        pcpend_d = pc_wb;
        if (ir_q[DEST_LO+1]) d_d = alu_out;
        if (ir_q[DEST_HI])   a_d = alu_out;
        if (ir_q[DEST_LO]) begin
          state_d = MEM_WR;
`ifdef HACK_CPU_HALT_DET_EN
          hpend_d = halt_hit;
`endif
        end else begin
          pc_d     = pc_wb;
          retire_d = 1'b1;
          state_d  = FETCH;
`ifdef HACK_CPU_HALT_DET_EN
          if (halt_hit) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
`endif
        end
      end
      MEM_WR: begin
        if (dmem_ack) begin
          pc_d     = pcpend_q;
          retire_d = 1'b1;
          state_d  = FETCH;
`ifdef HACK_CPU_HALT_DET_EN
          if (hpend_q) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
`endif
        end
      end
`ifdef HACK_CPU_HALT_DET_EN
      HALT: state_d = HALT;
`endif
      default: state_d = FETCH;
    endcase
  end

  assign imem_req   = rst_sync_q[1] && (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign dmem_we    = (state_q == MEM_WR);
  assign dmem_addr  = (state_q == MEM_WR) ? aold_q :
                      (state_q == MEM_RD) ? a_q[AW-1:0] : '0;
  assign dmem_wdata = (state_q == MEM_WR) ? wdata_q : '0;
  assign alu_x      = d_q;
  assign alu_y      = ir_q[ABIT] ? m_q : a_q;
  assign alu_ctl    = ir_q[CI] ? ir_q[COMP_HI:COMP_LO] : 6'b0;
  assign pc_o       = pc_q;
  assign a_o        = a_q;
  assign d_o        = d_q;
  assign retire     = retire_q;

endmodule

`default_nettype wire

// File: tb/tb_hack_cpu_ctrl.sv
// ============================================================================
// tb_hack_cpu_ctrl : instruction-level reference model bench for hack_cpu_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_valid, dmem_req, dmem_we, dmem_ack;
  logic [14:0] imem_addr, dmem_addr, pc_o;
  logic [15:0] imem_rdata, dmem_wdata, dmem_rdata, alu_x, alu_y, alu_out, a_o, d_o;
  logic [5:0]  alu_ctl;
  logic        alu_zr, alu_ng, retire, halted;

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.AW(15), .RESET_PC(15'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl), .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc_o(pc_o), .a_o(a_o), .d_o(d_o), .retire(retire), .halted(halted)
  );

  function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? xx + yy : xx & yy;
    return c[0] ? ~o : o;
  endfunction

  // Neighbouring combinational ALU
  assign alu_out = alu_f(alu_x, alu_y, alu_ctl);
  assign alu_zr  = (alu_out == 16'h0);
  assign alu_ng  = alu_out[15];

  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];

  int nchecks = 0, nerrs = 0;
  int cyc, n_ret, first_req_cyc, ret1_cyc, n_wr, wlen, wr_seen, rd_seen;
  logic [14:0] m_pc, m_pc_pre, exp_addr;
  logic [15:0] m_a, m_d, exp_wdata, cur_ir;
  bit          m_halt, exp_wr, exp_rd, dir_mode, i_act, d_act;
  int          i_left, d_left;
  bit          p_ireq, p_ival, p_dreq, p_dack, p_dwe;
  logic [14:0] p_iaddr, p_daddr;
  logic [15:0] p_dwdata;
  logic [14:0] wl_addr[$];
  logic [15:0] wl_data[$];
  int          wl_len[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural effect of one instruction, from the ISA rules.
  task automatic iss_step(input logic [15:0] ins);
    logic [15:0] y, o;
    bit take;
    m_pc_pre = m_pc;
    wr_seen = 0; rd_seen = 0; exp_wr = 0; exp_rd = 0;
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = m_pc + 15'd1;
    end else begin
      exp_rd    = ins[12];
      exp_addr  = m_a[14:0];
      y         = ins[12] ? dmem[m_a[14:0]] : m_a;
      o         = alu_f(m_d, y, ins[11:6]);
      exp_wr    = ins[3];
      exp_wdata = o;
      take = (ins[2] && $signed(o) < 0) || (ins[1] && o == 16'h0) || (ins[0] && $signed(o) > 0);
`ifdef HACK_CPU_HALT_DET_EN
      if (ins[2:0] == 3'b111 && exp_addr == m_pc) m_halt = 1;
`endif
      if (ins[4]) m_d = o;
      if (ins[5]) m_a = o;
      m_pc = take ? exp_addr : m_pc + 15'd1;
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_pc_pre = 0; m_a = 0; m_d = 0; m_halt = 0; cur_ir = 0;
    exp_wr = 0; exp_rd = 0; wr_seen = 0; rd_seen = 0; exp_addr = 0; exp_wdata = 0;
    i_act = 0; d_act = 0; i_left = 0; d_left = 0; wlen = 0;
    p_ireq = 0; p_ival = 0; p_dreq = 0; p_dack = 0; p_dwe = 0;
    p_iaddr = 0; p_daddr = 0; p_dwdata = 0;
    n_ret = 0; cyc = 0; first_req_cyc = -1; ret1_cyc = -1;
  endtask

  function automatic int pick_wait();
    return ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 4));
  endfunction

  task automatic check_cycle();
    logic [5:0] ectl;
    if (retire) begin
      n_ret++;
      if (n_ret == 1) ret1_cyc = cyc;
      chk("pc", pc_o, m_pc);
      chk("a", a_o, m_a);
      chk("d", d_o, m_d);
      chk("writes", wr_seen, exp_wr);
      chk("reads", rd_seen, exp_rd);
      chk("halted", halted, m_halt);
    end
    ectl = cur_ir[15] ? cur_ir[11:6] : 6'h0;
    chk("alu_ctl", alu_ctl, ectl);
    if (dmem_req && p_dreq && !p_dack)
      chk("dmem_stable", {dmem_addr, dmem_we, dmem_wdata}, {p_daddr, p_dwe, p_dwdata});
    if (imem_req && p_ireq && !p_ival)
      chk("imem_stable", imem_addr, p_iaddr);
    if (dmem_req && dmem_we) chk("pc_hold", pc_o, m_pc_pre);
    if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
    cyc++;
  endtask

  task automatic drive();
    if (imem_req) begin
      if (!i_act) begin i_act = 1; i_left = dir_mode ? 0 : pick_wait(); end
      if (i_left == 0) begin
        imem_valid = 1'b1;
        imem_rdata = imem[imem_addr];
        chk("fetch_addr", imem_addr, m_pc);
        iss_step(imem_rdata);
        cur_ir = imem_rdata;
        i_act = 0;
      end else begin
        i_left--; imem_valid = 1'b0; imem_rdata = 16'($urandom);
      end
    end else begin
      i_act = 0;
      imem_valid = !dir_mode && ($urandom_range(0, 7) == 0);
      imem_rdata = 16'($urandom);
    end
    p_ireq = imem_req; p_ival = imem_req && imem_valid; p_iaddr = imem_addr;

    if (dmem_req) begin
      if (dmem_we) wlen++;
      if (!d_act) begin
        d_act = 1;
        if (dir_mode) d_left = (dmem_we && n_wr == 0) ? 3 : (dmem_we && n_wr == 2) ? 1000 : 0;
        else          d_left = pick_wait();
      end
      if (d_left == 0) begin
        dmem_ack = 1'b1; d_act = 0;
        if (dmem_we) begin
          chk("wr_addr", dmem_addr, exp_addr);
          chk("wr_data", dmem_wdata, exp_wdata);
          dmem[dmem_addr] = dmem_wdata;
          wl_addr.push_back(dmem_addr); wl_data.push_back(dmem_wdata); wl_len.push_back(wlen);
          wlen = 0; n_wr++; wr_seen++;
          dmem_rdata = 16'($urandom);
        end else begin
          chk("rd_addr", dmem_addr, exp_addr);
          dmem_rdata = dmem[dmem_addr];
          rd_seen++;
        end
      end else begin
        d_left--; dmem_ack = 1'b0; dmem_rdata = 16'($urandom);
      end
    end else begin
      d_act = 0;
      dmem_ack = !dir_mode && ($urandom_range(0, 7) == 0);
      dmem_rdata = 16'($urandom);
    end
    p_dreq = dmem_req; p_dack = dmem_req && dmem_ack; p_daddr = dmem_addr;
    p_dwe = dmem_we; p_dwdata = dmem_wdata;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    drive();
  endtask

  task automatic run_until(input int target, output bit ok);
    int k;
    k = 0;
    while (n_ret < target && k < 500) begin step(); k++; end
    ok = (n_ret >= target);
    if (!ok) begin
      nchecks++; nerrs++;
      $display("FAIL retire_timeout: got %0d retires required %0d", n_ret, target);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_valid = 1'b0; dmem_ack = 1'b0; imem_rdata = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {imem_req, dmem_req, dmem_we, retire, halted, alu_ctl}, 32'h0);
    chk("reset_ad", {a_o, d_o}, 32'h0);
    chk("reset_pc", {17'h0, pc_o, imem_addr}, 32'h0);
    chk("reset_dmem", {dmem_addr, dmem_wdata}, 32'h0);
    chk("reset_alu", {alu_x, alu_y}, 32'h0);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    bit ok;
    int cnt;
    imem_valid = 0; dmem_ack = 0; imem_rdata = 0; dmem_rdata = 0;
    n_wr = 0;
    dir_mode = 1;
    for (int i = 0; i < 32768; i++) begin imem[i] = 16'h0; dmem[i] = 16'h0; end
    imem[0] = 16'h0005; imem[1] = 16'h0011; imem[2] = 16'hEC10; imem[3] = 16'h0003;
    imem[4] = 16'hE090; imem[5] = 16'h0064; imem[6] = 16'hE308; imem[7] = 16'hFDE8;
    imem[8] = 16'hEE90; imem[9] = 16'h000C; imem[10] = 16'hE304; imem[11] = 16'h0000;
    imem[12] = 16'hEA90; imem[13] = 16'h0007; imem[14] = 16'hE304; imem[15] = 16'hE308;
    do_reset();

    run_until(1, ok);
    chk("lit_a_latency", ret1_cyc - first_req_cyc, 2);
    chk("lit_a5", a_o, 16'd5);
    chk("lit_pc1", pc_o, 15'd1);
    run_until(5, ok);
    chk("lit_d20", d_o, 16'd20);
    chk("lit_ctl_dplusa", alu_ctl, 6'b000010);
    run_until(7, ok);
    if (wl_addr.size() >= 1) begin
      chk("lit_w0_addr", wl_addr[0], 15'd100);
      chk("lit_w0_data", wl_data[0], 16'd20);
      chk("lit_w0_len", wl_len[0], 4);
    end else chk("lit_w0_seen", wl_addr.size(), 1);
    run_until(8, ok);
    chk("lit_a21", a_o, 16'd21);
    if (wl_addr.size() >= 2) chk("lit_w1", {wl_addr[1], wl_data[1]}, {15'd100, 16'd21});
    else chk("lit_w1_seen", wl_addr.size(), 2);
    run_until(11, ok);
    chk("lit_jlt_taken", pc_o, 15'd12);
    run_until(14, ok);
    chk("lit_jlt_not", pc_o, 15'd15);

    // Reset in the middle of a stalled write
    cnt = 0;
    for (int k = 0; k < 50 && cnt < 2; k++) begin
      step();
      if (dmem_req && dmem_we) cnt++;
    end
    chk("wr_pending_seen", cnt, 2);
    #2 rst_n = 1'b0;
    #1 chk("reset_drops_req", {imem_req, dmem_req, dmem_we}, 32'h0);
    @(negedge clk); dmem_ack = 1'b1; imem_valid = 1'b1; imem_rdata = 16'hE308;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); dmem_ack = 1'b0; imem_valid = 1'b0;
    chk("late_ack_ignored", {dmem_req, a_o, d_o}, 32'h0);
    model_reset();
    n_wr = 3;
    run_until(1, ok);
    chk("lit_restart_pc", pc_o, 15'd1);
    chk("lit_restart_a", a_o, 16'd5);

`ifdef HACK_CPU_HALT_DET_EN
    for (int i = 0; i < 8; i++) imem[i] = 16'h0000;
    imem[3] = 16'h0004; imem[4] = 16'hEA87;
    do_reset();
    run_until(5, ok);
    chk("lit_halted", halted, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("halt_no_fetch", imem_req, 1'b0);
    end
    chk("halt_retire_once", n_ret, 5);
`endif

    // Randomised programs with random wait states and stray valid/ack
    dir_mode = 0;
    for (int i = 0; i < 32768; i++) begin
      imem[i] = ($urandom_range(0, 1) == 1) ? {1'b0, 15'($urandom)} : {3'b111, 13'($urandom)};
      dmem[i] = 16'($urandom);
    end
    do_reset();
    ok = 1;
    while (ok && n_ret < 1500) begin
      run_until(n_ret + 1, ok);
      if (m_halt) break;
    end

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrs);
    $finish;
  end

endmodule

`default_nettype wire
